// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, even parity, stop.
// Ports: clk, rst (async high), sin, en (bit strobe) -> data, valid, perr, ferr, busy.
module serial_frame_receiver #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sin,
    input  logic              en,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              perr,
    output logic              ferr,
    output logic              busy
);

    localparam int CW = $clog2(DATA_W + 1);

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     count_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              par_q;
    logic [DATA_W-1:0] data_q;
    logic              perr_q;
    logic              valid_q;
    logic              ferr_q;
    logic              last_bit;

    assign last_bit = (count_q == CW'(DATA_W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case (state_q)
                IDLE: if (!sin) state_d = DATA;
                DATA: if (last_bit) state_d = PAR;
                PAR:  state_d = STOP;
                STOP: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Place the incoming bit at the position selected by the counter.
    always_comb begin
        shift_d = shift_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (count_q == CW'(i)) shift_d[i] = sin;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            perr_q  <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (en) begin
                unique case (state_q)
                    IDLE: if (!sin) count_q <= '0;
                    DATA: begin
                        shift_q <= shift_d;
                        count_q <= count_q + CW'(1);
                    end
                    // Even parity: data bits plus parity bit must XOR to 0.
                    PAR: par_q <= (^shift_q) ^ sin;
                    STOP: begin
                        if (sin) begin
                            data_q  <= shift_q;
                            perr_q  <= par_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        busy  = (state_q != IDLE);
        data  = data_q;
        valid = valid_q;
        perr  = perr_q;
        ferr  = ferr_q;
    end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver (DATA_W=8).
// Drives frames bit by bit and checks data/valid/perr/ferr/busy.
module tb_serial_frame_receiver;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       en;
    logic [7:0] data;
    logic       valid;
    logic       perr;
    logic       ferr;
    logic       busy;

    int n_vec;
    int n_err;

    // Results captured by send_frame.
    int         v_cnt;
    int         v_edge;
    int         f_cnt;
    int         f_edge;
    int         both;
    logic [7:0] cap_data;
    logic       cap_perr;

    serial_frame_receiver #(.DATA_W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .sin   (sin),
        .en    (en),
        .data  (data),
        .valid (valid),
        .perr  (perr),
        .ferr  (ferr),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge with the given sin/en; returns 1 ns after the edge.
    task automatic drive(input logic b, input logic e);
        @(negedge clk);
        sin = b;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    // Sends one 11-bit frame; gap=1 inserts a disabled edge after each bit.
    task automatic send_frame(input logic [7:0] d, input logic p,
                              input logic s, input logic gap);
        logic [10:0] bits;
        bits     = {s, p, d, 1'b0};
        v_cnt    = 0;
        v_edge   = 0;
        f_cnt    = 0;
        f_edge   = 0;
        both     = 0;
        cap_data = 8'h00;
        cap_perr = 1'b0;
        for (int i = 0; i < 11; i++) begin
            drive(bits[i], 1'b1);
            if (valid) begin
                v_cnt++;
                v_edge   = i + 1;
                cap_data = data;
                cap_perr = perr;
            end
            if (ferr) begin
                f_cnt++;
                f_edge = i + 1;
            end
            if (valid && ferr) both++;
            if (i == 0) chk("busy_after_start", busy, 1);
            if (i == 10) chk("busy_after_stop", busy, 0);
            if (gap) begin
                drive(1'b1, 1'b0);
                if (valid) v_cnt++;
                if (ferr) f_cnt++;
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        sin   = 1'b1;
        en    = 1'b0;

        #2;
        chk("rst_data", data, 8'h00);
        chk("rst_valid", valid, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_busy", busy, 0);

        @(negedge clk);
        rst = 1'b0;

        // Idle line held high: nothing happens.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1);
            chk("idle_busy", busy, 0);
            chk("idle_valid", valid, 0);
        end

        // 0xA5 good parity.
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        chk("a5_vcnt", v_cnt, 1);
        chk("a5_vedge", v_edge, 11);
        chk("a5_data", cap_data, 8'hA5);
        chk("a5_perr", cap_perr, 0);
        chk("a5_fcnt", f_cnt, 0);

        // 0xA5 bad parity.
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        chk("a5p_vcnt", v_cnt, 1);
        chk("a5p_data", cap_data, 8'hA5);
        chk("a5p_perr", cap_perr, 1);

        // 0x3C with bad stop bit.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("3c_fcnt", f_cnt, 1);
        chk("3c_fedge", f_edge, 11);
        chk("3c_vcnt", v_cnt, 0);
        chk("3c_both", both, 0);
        chk("3c_data_kept", data, 8'hA5);
        chk("3c_perr_kept", perr, 1);
        drive(1'b1, 1'b1);
        chk("3c_ferr_1cyc", ferr, 0);

        // 0x5A with en toggling 1,0,1,0.
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        chk("5a_vcnt", v_cnt, 1);
        chk("5a_vedge", v_edge, 11);
        chk("5a_data", cap_data, 8'h5A);
        chk("5a_perr", cap_perr, 0);
        chk("5a_fcnt", f_cnt, 0);

        // Reset mid-frame: start + 4 data bits of 0xC3, then rst 20 ns later.
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        chk("mid_busy_pre", busy, 1);
        en = 1'b0;
        #19;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_data", data, 8'h00);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_ferr", ferr, 0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        chk("ff_vcnt", v_cnt, 1);
        chk("ff_vedge", v_edge, 11);
        chk("ff_data", cap_data, 8'hFF);
        chk("ff_perr", cap_perr, 0);

        // Back-to-back 0x01 then 0x80, no idle bits.
        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        chk("b2b1_vedge", v_edge, 11);
        chk("b2b1_data", cap_data, 8'h01);
        chk("b2b1_perr", cap_perr, 0);
        send_frame(8'h80, 1'b1, 1'b1, 1'b0);
        chk("b2b2_vcnt", v_cnt, 1);
        chk("b2b2_vedge", v_edge, 11);
        chk("b2b2_data", cap_data, 8'h80);
        chk("b2b2_perr", cap_perr, 0);

        drive(1'b1, 1'b1);
        chk("end_valid", valid, 0);
        chk("end_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
